// File: rtl/if_id_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Core-wide instruction bus widths and constant words shared by
//               the fetch->decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_queue_pkg;

    localparam int c_inst_bus_w      = 32;
    localparam int c_inst_addr_bus_w = 32;

    // addi x0, x0, 0
    localparam logic [c_inst_bus_w-1:0]      c_inst_nop  = 32'h00000013;
    localparam logic [c_inst_addr_bus_w-1:0] c_zero_word = 32'h00000000;

endpackage
`default_nettype wire

// File: rtl/if_id_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue_ctrl
// Description : Pointer, occupancy and handshake control for the IF/ID queue.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue_ctrl
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_in_valid,
    input  logic                     i_flush,
    input  logic                     i_stall,
    output logic                     o_in_ready,
    output logic                     o_out_valid,
    output logic                     o_wr_en,
    output logic [$clog2(DEPTH)-1:0] o_wr_idx,
    output logic [$clog2(DEPTH)-1:0] o_rd_idx,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;
    logic               w_in_ready;
    logic               w_out_valid;

    // Ready depends on occupancy only, so a full queue refuses even while popping.
    assign w_in_ready  = (r_count < c_cnt_w'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = i_in_valid & w_in_ready;
    assign w_pop       = w_out_valid & ~i_stall;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_wr_en     = w_push & ~i_flush & ~rst;
    assign o_wr_idx    = r_wr_ptr;
    assign o_rd_idx    = r_rd_ptr;
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : DEPTH-entry valid/ready instruction queue between fetch and
//               decode; presents a NOP at address 0 whenever it is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int                INST_W   = c_inst_bus_w,
    parameter int                ADDR_W   = c_inst_addr_bus_w,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = c_inst_nop
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [INST_W-1:0]        inst_i,
    input  logic [ADDR_W-1:0]        inst_addr_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    output logic                     out_valid_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        inst_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [INST_W-1:0]  r_mem_inst [DEPTH];
    logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
    logic               w_wr_en;
    logic [c_ptr_w-1:0] w_wr_idx;
    logic [c_ptr_w-1:0] w_rd_idx;
    logic               w_out_valid;

    if_id_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid_i),
        .i_flush     (flush_i),
        .i_stall     (stall_i),
        .o_in_ready  (in_ready_o),
        .o_out_valid (w_out_valid),
        .o_wr_en     (w_wr_en),
        .o_wr_idx    (w_wr_idx),
        .o_rd_idx    (w_rd_idx),
        .o_count     (count_o)
    );

    // Storage needs no reset: entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_inst[w_wr_idx] <= inst_i;
            r_mem_addr[w_wr_idx] <= inst_addr_i;
        end
    end

    assign out_valid_o = w_out_valid;
    assign inst_o      = w_out_valid ? r_mem_inst[w_rd_idx] : NOP_INST;
    assign inst_addr_o = w_out_valid ? r_mem_addr[w_rd_idx] : ADDR_W'(c_zero_word);

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Self-checking bench for if_id_queue: vector table plus a
//               scoreboarded fill/wrap sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        flush_i;
    logic        stall_i;
    logic        out_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [2:0]  count_o;

    if_id_queue #(
        .INST_W   (32),
        .ADDR_W   (32),
        .DEPTH    (4),
        .NOP_INST (c_nop)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .out_valid_o (out_valid_o),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vin;
        logic [31:0] inst;
        logic [31:0] addr;
        logic        flush;
        logic        stall;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        logic [2:0]  e_count;
        logic        e_ready;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(input logic r, input logic vin, input logic [31:0] inst,
                                input logic [31:0] addr, input logic fl, input logic st,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ea,
                                input logic [2:0] ec, input logic er);
        vec_t t;
        t.rst = r; t.vin = vin; t.inst = inst; t.addr = addr; t.flush = fl; t.stall = st;
        t.e_valid = ev; t.e_inst = ei; t.e_addr = ea; t.e_count = ec; t.e_ready = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic vin, input logic [31:0] inst,
                         input logic [31:0] addr, input logic fl, input logic st);
        rst = r; in_valid_i = vin; inst_i = inst; inst_addr_i = addr;
        flush_i = fl; stall_i = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill_wrap();
        int model_cnt;
        int pend_idx;
        int cyc;
        logic pop;
        logic acc;
        logic [63:0] exp_e;
        logic [31:0] pend_inst [4];
        logic [31:0] pend_addr [4];

        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        sb.delete();
        // A..D with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'hA0000000 + 32'(i), 32'h00000300 + 32'(4 * i), 1'b0, 1'b1);
            sb.push_back({32'h00000300 + 32'(4 * i), 32'hA0000000 + 32'(i)});
            step();
        end
        chk("fill_count", 32'(count_o), 32'd4);
        chk("fill_ready", 32'(in_ready_o), 32'd0);
        chk("fill_head", inst_o, 32'hA0000000);
        // Fifth push while full and stalled must be refused
        drive(1'b0, 1'b1, 32'hDEADBEEF, 32'h0000BAD0, 1'b0, 1'b1);
        step();
        chk("full_refuse_count", 32'(count_o), 32'd4);
        chk("full_refuse_ready", 32'(in_ready_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            pend_inst[i] = 32'hE0000000 + 32'(i);
            pend_addr[i] = 32'h00000310 + 32'(4 * i);
        end
        model_cnt = 4;
        pend_idx  = 0;
        cyc       = 0;
        while ((sb.size() > 0 || pend_idx < 4) && cyc < 40) begin
            pop = 1'b0;
            acc = 1'b0;
            if (model_cnt > 0) begin
                exp_e = sb.pop_front();
                chk("wrap_valid", 32'(out_valid_o), 32'd1);
                chk("wrap_inst", inst_o, exp_e[31:0]);
                chk("wrap_addr", inst_addr_o, exp_e[63:32]);
                pop = 1'b1;
            end else begin
                chk("wrap_empty_valid", 32'(out_valid_o), 32'd0);
            end
            if (pend_idx < 4) begin
                drive(1'b0, 1'b1, pend_inst[pend_idx], pend_addr[pend_idx], 1'b0, 1'b0);
                if (model_cnt < 4) begin
                    sb.push_back({pend_addr[pend_idx], pend_inst[pend_idx]});
                    pend_idx++;
                    acc = 1'b1;
                end
            end else begin
                drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            end
            model_cnt = model_cnt + int'(acc) - int'(pop);
            step();
            chk("wrap_count", 32'(count_o), 32'(model_cnt));
            cyc++;
        end
        if (sb.size() > 0 || pend_idx < 4) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_timeout: got %0d pending expected 0", sb.size() + (4 - pend_idx));
        end
        chk("wrap_final_valid", 32'(out_valid_o), 32'd0);
        chk("wrap_final_inst", inst_o, c_nop);
    endtask

    initial begin
        drive(1'b1, 1'b1, 32'h11111111, 32'h40, 1'b0, 1'b0);

        // reset held two cycles with fetch valid
        vecs.push_back(mk(1, 1, 32'h11111111, 32'h40, 0, 0, 0, c_nop, 32'h0, 3'd0, 1));
        vecs.push_back(mk(1, 1, 32'h11111111, 32'h40, 0, 0, 0, c_nop, 32'h0, 3'd0, 1));
        // pass-through then drain
        vecs.push_back(mk(0, 1, 32'h00500093, 32'h80000000, 0, 0, 1, 32'h00500093, 32'h80000000, 3'd1, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, c_nop, 32'h0, 3'd0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 1, 0, c_nop, 32'h0, 3'd0, 1));
        // push+pop at count 1 swaps the head
        vecs.push_back(mk(0, 1, 32'h00100113, 32'h100, 0, 0, 1, 32'h00100113, 32'h100, 3'd1, 1));
        vecs.push_back(mk(0, 1, 32'h00200193, 32'h104, 0, 0, 1, 32'h00200193, 32'h104, 3'd1, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, c_nop, 32'h0, 3'd0, 1));
        // flush at count 3 with a concurrent push
        vecs.push_back(mk(0, 1, 32'h00300213, 32'h200, 0, 1, 1, 32'h00300213, 32'h200, 3'd1, 1));
        vecs.push_back(mk(0, 1, 32'h00400293, 32'h204, 0, 1, 1, 32'h00300213, 32'h200, 3'd2, 1));
        vecs.push_back(mk(0, 1, 32'h00500313, 32'h208, 0, 1, 1, 32'h00300213, 32'h200, 3'd3, 1));
        vecs.push_back(mk(0, 1, 32'h00600393, 32'h20C, 1, 0, 0, c_nop, 32'h0, 3'd0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, c_nop, 32'h0, 3'd0, 1));
        // reset together with flush at count 2, then a fresh push
        vecs.push_back(mk(0, 1, 32'h00700413, 32'h400, 0, 1, 1, 32'h00700413, 32'h400, 3'd1, 1));
        vecs.push_back(mk(0, 1, 32'h00800493, 32'h404, 0, 1, 1, 32'h00700413, 32'h400, 3'd2, 1));
        vecs.push_back(mk(1, 1, 32'h00900513, 32'h408, 1, 0, 0, c_nop, 32'h0, 3'd0, 1));
        vecs.push_back(mk(0, 1, 32'h00A00593, 32'h500, 0, 0, 1, 32'h00A00593, 32'h500, 3'd1, 1));
        vecs.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, c_nop, 32'h0, 3'd0, 1));

        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vin, vecs[i].inst, vecs[i].addr, vecs[i].flush, vecs[i].stall);
            step();
            chk($sformatf("v%0d_valid", i), 32'(out_valid_o), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_inst", i), inst_o, vecs[i].e_inst);
            chk($sformatf("v%0d_addr", i), inst_addr_o, vecs[i].e_addr);
            chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_ready", i), 32'(in_ready_o), 32'(vecs[i].e_ready));
        end

        run_fill_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
